// File: rtl/physics_step_engine.sv
// Physics sweep engine: reads the object table in batches of 4, applies one Euler step with
// gravity, and writes each non-static object back through a single write port.
module physics_step_engine #(
   parameter int                 OBJ_WIDTH    = 96,
   parameter int                 ADDR_WIDTH   = 6,
   parameter int                 OBJ_COUNT    = 64,
   parameter int                 READ_LATENCY = 2,
   parameter logic signed [15:0] GRAVITY      = 16'sd1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  read_valid_out,
   output logic [ADDR_WIDTH-1:0] read_addrs_out [3:0],
   input  logic [OBJ_WIDTH-1:0]  read_objects_in [3:0],
   output logic                  write_valid_out,
   output logic [ADDR_WIDTH-1:0] write_addr_out,
   output logic [OBJ_WIDTH-1:0]  write_object_out,
   output logic [2:0]            state_dbg
);

   // Handshake: read_valid_out qualifies read_addrs_out for one cycle, and the storage returns
   // data READ_LATENCY cycles later with no backpressure; write_valid_out qualifies
   // write_addr_out/write_object_out for exactly the cycle it is high.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_WIDTH:0] COUNT_EXT = (ADDR_WIDTH+1)'(OBJ_COUNT);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CW-1:0]         wait_cnt_q;
   logic [1:0]            lane_q;
   logic [OBJ_WIDTH-1:0]  hold_obj_q [3:0];
   logic [3:0]            hold_valid_q;
   logic [3:0]            lane_ok;
   logic                  last_batch;
   logic                  capture;

   logic [OBJ_WIDTH-1:0]  cur;
   logic [15:0]           px, py, vx, vy, vy_new;
   logic [16:0]           vy_sum;
   logic [OBJ_WIDTH-1:0]  upd;

   // Bounds compares are one bit wider than the address so OBJ_COUNT = 2^ADDR_WIDTH works.
   always_comb begin
      lane_ok = '0;
      for (int i = 0; i < 4; i++) begin
         lane_ok[i] = ({1'b0, base_q} + (ADDR_WIDTH+1)'(i)) < COUNT_EXT;
      end
      last_batch = ({1'b0, base_q} + (ADDR_WIDTH+1)'(4)) >= COUNT_EXT;
      capture    = (state_q == S_WAIT) && (wait_cnt_q == CW'(READ_LATENCY-1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_in) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (capture) state_d = S_WRITE;
         S_WRITE: if (lane_q == 2'd3) state_d = last_batch ? S_DONE : S_ISSUE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         wait_cnt_q   <= '0;
         lane_q       <= '0;
         hold_valid_q <= '0;
         for (int i = 0; i < 4; i++) hold_obj_q[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (start_in) base_q <= '0;
            S_ISSUE: wait_cnt_q <= '0;
            S_WAIT: begin
               wait_cnt_q <= wait_cnt_q + 1'b1;
               if (capture) begin
                  for (int i = 0; i < 4; i++) hold_obj_q[i] <= read_objects_in[i];
                  hold_valid_q <= lane_ok;
                  lane_q       <= '0;
               end
            end
            S_WRITE: begin
               lane_q <= lane_q + 1'b1;
               if (lane_q == 2'd3 && !last_batch) base_q <= base_q + ADDR_WIDTH'(4);
            end
            default: ;
         endcase
      end
   end

   // Euler step: velocity first (saturating), then position uses the new vel_y.
   always_comb begin
      cur    = hold_obj_q[lane_q];
      px     = cur[63:48];
      py     = cur[47:32];
      vx     = cur[31:16];
      vy     = cur[15:0];
      vy_sum = {vy[15], vy} + {GRAVITY[15], GRAVITY};
      if (vy_sum[16] != vy_sum[15]) vy_new = vy_sum[16] ? 16'h8000 : 16'h7FFF;
      else                          vy_new = vy_sum[15:0];
      upd = {cur[OBJ_WIDTH-1:64], px + vx, py + vy_new, vx, vy_new};
   end

   always_comb begin
      busy_out         = (state_q != S_IDLE);
      done_out         = (state_q == S_DONE);
      read_valid_out   = (state_q == S_ISSUE);
      write_valid_out  = 1'b0;
      write_addr_out   = '0;
      write_object_out = '0;
      for (int i = 0; i < 4; i++) begin
         read_addrs_out[i] = read_valid_out ? base_q + ADDR_WIDTH'(i) : '0;
      end
      if (state_q == S_WRITE) begin
         write_valid_out  = hold_valid_q[lane_q] && !cur[OBJ_WIDTH-1];
         write_addr_out   = base_q + ADDR_WIDTH'(lane_q);
         write_object_out = upd;
      end
      state_dbg = state_q;
   end

endmodule

// File: doc/physics_step_engine.md
Name: physics_step_engine

Overview:
- Frame-rate physics sweep engine that sits directly upstream of the object storage block.
- On each start pulse it walks the object table in batches of 4, issuing reads on the storage's 4 read ports.
- It applies one explicit-Euler integration step with gravity to each non-static object and writes results back through the storage's single write port.

Parameters:
- OBJ_WIDTH, 96: object word width; bit OBJ_WIDTH-1 = is_static; bits [63:0] = {pos_x, pos_y, vel_x, vel_y}, 16-bit signed each, vel_y in [15:0].
- ADDR_WIDTH, 6: object address width.
- OBJ_COUNT, 64: number of valid objects; 1..2^ADDR_WIDTH.
- READ_LATENCY, 2: cycles from read_valid_out/address to valid read_objects_in; matches storage in high-performance mode.
- GRAVITY, 16'sd1: signed value added to vel_y per step.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: synchronous active-high reset.
- start_in, input, 1: one-cycle request to run one physics step over all objects.
- busy_out, output, 1: high from the cycle after an accepted start until done.
- done_out, output, 1: one-cycle pulse when the sweep completes.
- read_valid_out, output, 1: read request strobe to storage.
- read_addrs_out[3:0], output, ADDR_WIDTH each: lane i address = base+i.
- read_objects_in[3:0], input, OBJ_WIDTH each: storage read data.
- write_valid_out, output, 1: write strobe to storage.
- write_addr_out, output, ADDR_WIDTH: write address.
- write_object_out, output, OBJ_WIDTH: updated object.

Behaviour:
- Clock and reset: one clock (clk_in); reset is synchronous and active-high (rst_in).
- Reset values: state IDLE, base=0, busy_out=0, done_out=0, read_valid_out=0, write_valid_out=0; address/data outputs 0.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - start_in=1 -> ISSUE, base=0, busy_out=1 next cycle.
  - start_in is ignored in every other state; no queuing.
- ISSUE (1 cycle):
  - read_valid_out=1; read_addrs_out[i]=base+i, ADDR_WIDTH wrap.
  - Lane i is valid iff base+i < OBJ_COUNT; compute the compare in ADDR_WIDTH+1 bits.
  - -> WAIT.
- WAIT:
  - Counter runs READ_LATENCY cycles after ISSUE.
  - On the cycle read data is valid, all 4 lanes are registered into a holding buffer, with the valid mask alongside.
  - -> WRITE.
- WRITE: 4 cycles, lane 0..3 in order.
  - Each cycle: write_valid_out=1 iff lane valid AND is_static=0.
  - write_addr_out=base+lane; write_object_out=updated word.
  - Then: if base+4 >= OBJ_COUNT -> DONE, else base+=4 -> ISSUE.
- DONE (1 cycle): done_out=1, busy_out=0 next cycle -> IDLE.
- Update arithmetic, all 16-bit signed:
  - vel_y' = saturate(vel_y + GRAVITY) to [-32768, 32767].
  - vel_x' = vel_x.
  - pos_x' = pos_x + vel_x, wrapping mod 2^16.
  - pos_y' = pos_y + vel_y', wrapping.
  - Bits [OBJ_WIDTH-1:64] pass through unchanged.
- Static objects and invalid lanes produce no write.
- Hazard: reads for a batch complete before any write of that batch; batches are disjoint, so there is no read-after-write hazard.
- Read data is sampled only at the latency point; read_objects_in is ignored at all other times.
- Reset mid-sweep: immediate return to IDLE next cycle. No further writes; partial table update is accepted. done_out is not pulsed.
- Timing: one batch = 1 + READ_LATENCY + 4 cycles (7 default). Full sweep of 64 objects = 16 batches + 1 DONE = 113 cycles from start acceptance.

Test Plan:
- Object 0 = {static=0, pos_x=100, pos_y=50, vel_x=3, vel_y=-2}, OBJ_COUNT=4, start pulse -> write addr 0 with pos_x=103, pos_y=49, vel_y=-1, vel_x=3; done_out pulses exactly 1 cycle after the 4th WRITE cycle; total 8 cycles.
- Object 2 static with arbitrary data -> no write_valid_out to addr 2; its storage contents are unchanged after sweep.
- OBJ_COUNT=6 -> second batch issues addrs 4..7; writes only to 4 and 5; no write to 6 or 7; done after 2 batches.
- vel_y=32767, GRAVITY=1 -> vel_y'=32767 (saturated). pos_x=32767, vel_x=1 -> pos_x'=-32768 (wrap).
- start_in held high throughout the sweep -> exactly one sweep, then a new sweep begins from IDLE on the next start cycle; busy_out deasserts for ≥1 cycle between sweeps.
- rst_in asserted during WRITE of batch 3 -> next cycle all strobes 0, busy_out=0, no done_out; a following start performs a full sweep from addr 0.
